aes_cbc_chain_ctrl: RTL and testbench
=====================================

Name: aes_cbc_chain_ctrl

Overview:
Sequential CBC-mode front end for the combinational CBC encrypt core (`aes_enc_top`: `in`, `iv`, `key` → `out`).
- Accepts a stream of 128-bit plaintext blocks over a valid/ready handshake.
- Holds key and chaining IV stable while the core evaluates.
- Registers each ciphertext block and feeds it back as the IV for the next block.
- Sits between the message source (DMA or bus regs) and the encrypt core; the ciphertext output goes to the downstream sink.

Parameters:
ENC_LAT, 1, clock edges allowed for the core to settle before `enc_out` is captured; legal range ≥1, 0 is illegal (elaboration check)
CNT_W, 16, width of `blk_cnt` (only used when AES_CBC_BLKCNT_EN is defined)

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous, active-high reset
start  input  1  pulse in IDLE: latch `key`/`iv_in`, begin message
key  input  128  AES key, sampled on accepted `start`
iv_in  input  128  initial IV, sampled on accepted `start`
pt_valid  input  1  plaintext block valid
pt_data  input  128  plaintext block
pt_last  input  1  marks final block of message
pt_ready  output  1  block can be accepted
ct_valid  output  1  ciphertext valid
ct_data  output  128  ciphertext block
ct_last  output  1  final ciphertext of message
ct_ready  input  1  sink accepts ciphertext
enc_in  output  128  to core `in` (plaintext)
enc_iv  output  128  to core `iv` (chaining value)
enc_key  output  128  to core `key`
enc_out  input  128  from core `out`
busy  output  1  high when state ≠ IDLE

Behaviour:
- Clock and reset: one clock `clk`; reset `rst` is synchronous and active-high.
- Reset values: state=IDLE; `pt_ready`=0, `ct_valid`=0, `ct_last`=0, `ct_data`=0, `busy`=0; internal `iv_reg`, `key_reg`, `pt_reg`, `last_reg`, `wait_cnt` = 0.
- Core drive: `enc_in`=`pt_reg`, `enc_iv`=`iv_reg`, `enc_key`=`key_reg`, continuously.
- Decoded outputs: `pt_ready`=(state==ACCEPT) and `busy`=(state≠IDLE), both decoded from the state register with no input-to-output combinational path.
- IDLE: on `start`=1, `iv_reg`←`iv_in`, `key_reg`←`key`, go to ACCEPT. `pt_valid` is ignored.
- ACCEPT: on `pt_valid`&`pt_ready`, `pt_reg`←`pt_data`, `last_reg`←`pt_last`, `wait_cnt`←0, go to WAIT.
- WAIT: `wait_cnt` increments each cycle. On the edge where `wait_cnt`==ENC_LAT-1:
  - `ct_data`←`enc_out`, `ct_last`←`last_reg`, `ct_valid`←1;
  - go to OUT.
  - Result: `ct_valid` rises exactly ENC_LAT edges after the plaintext handshake edge.
- OUT: `ct_valid`, `ct_data` and `ct_last` are held stable until `ct_ready`. On handshake:
  - `iv_reg`←`ct_data` (chaining), `ct_valid`←0;
  - next state is IDLE if `ct_last`, else ACCEPT.
- Throughput: at most one block per ENC_LAT+2 cycles. No overlap; the next plaintext is accepted only after the previous ciphertext is consumed.
- `start` outside IDLE is ignored. `key`/`iv_in` changes after the latch have no effect.
- `ct_ready` held high in OUT: handshake on the first OUT cycle.
- `rst` asserted mid-message: all registers return to reset values, the in-flight block is discarded with no `ct_valid` pulse, and the chaining IV is lost.
- `start` and `rst` in the same cycle: reset wins.

Optional Feature:
AES_CBC_BLKCNT_EN
- Defined: adds output port `blk_cnt` [CNT_W-1:0], reset 0.
  - Cleared to 0 on accepted `start`.
  - +1 on each ct handshake.
  - Saturates at all-ones; no wrap.
- Undefined: port and counter are absent; other behaviour is identical.

Decomposition:
- Package `aes_cbc_pkg`: AES_BLK_W=128; state encodings ST_IDLE, ST_ACCEPT, ST_WAIT, ST_OUT (2 bits).
- Sub-module `aes_cbc_lat_cnt`: ENC_LAT down/up counter with clear and done output.
- FSM, data registers and chaining logic stay in the top.
- The bench instantiates `aes_enc_top` alongside the block.

Test Plan:
- Reset, then idle with `pt_valid`=1 and no `start` → `pt_ready`=0, `ct_valid`=0, `busy`=0.
- SP800-38A F.2.1, 2-block message, `ct_ready`=1:
  - key=2b7e151628aed2a6abf7158809cf4f3c, iv=000102030405060708090a0b0c0d0e0f;
  - pt1=6bc1bee22e409f96e93d7e117393172a → ct=7649abac8119b246cee98e9b12e9197d, `ct_last`=0;
  - pt2=ae2d8a571e03ac9c9eb76fac45af8e51 (`pt_last`=1) → ct=5086cb9b507219ee95db113a917678b2, `ct_last`=1;
  - then IDLE.
- Latency, ENC_LAT=3 → `ct_valid` rises exactly 3 edges after the pt handshake edge.
- Backpressure: `ct_ready`=0 for 5 cycles → `ct_data` stable, `pt_ready`=0, `enc_iv` unchanged. Release → chaining continues and pt2 still yields 5086cb9b….
- Mid-message faults:
  - Pulse `rst` in WAIT → no ct emitted, `iv_reg`=0, state IDLE.
  - `start` asserted in OUT → ignored; `iv_reg` updates from ct, not from `iv_in`.
- With AES_CBC_BLKCNT_EN, CNT_W=2 → after 5 blocks `blk_cnt`=3 (saturated). A new `start` → `blk_cnt`=0.

Source files
------------

// File: rtl/aes_cbc_pkg.sv
// Shared definitions for the CBC chaining front end: block width and FSM encodings.
package aes_cbc_pkg;

  localparam int AES_BLK_W = 128;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCEPT = 2'd1,
    ST_WAIT   = 2'd2,
    ST_OUT    = 2'd3
  } state_t;

endpackage

// File: rtl/aes_cbc_lat_cnt.sv
// Settle-time counter for the combinational encrypt core. Cleared when a
// plaintext block is accepted, counts while enabled, and flags done on the
// cycle whose closing edge is the ENC_LAT-th edge after the clear.
module aes_cbc_lat_cnt #(
  parameter int ENC_LAT = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic done
);

  localparam int CW = (ENC_LAT > 1) ? $clog2(ENC_LAT) : 1;
  localparam logic [CW-1:0] LAST = CW'(ENC_LAT - 1);

  logic [CW-1:0] cnt;

  // Count up from zero, holding at the terminal value until cleared.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (en && !done) begin
      cnt <= cnt + CW'(1);
    end
  end

  assign done = (cnt == LAST);

endmodule

// File: rtl/aes_enc_top.sv
// Combinational AES-128 CBC encrypt step: out = AES_key(in ^ iv).
// Byte 0 of a block is bits [127:120]; state bytes are column-major.
module aes_enc_top (
  input  logic [127:0] in,
  input  logic [127:0] iv,
  input  logic [127:0] key,
  output logic [127:0] out
);

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // S-box from the GF(2^8) inverse (x^254) followed by the affine map.
  function automatic logic [7:0] sbox(input logic [7:0] b);
    logic [7:0] r;
    logic [7:0] base;
    logic [7:0] e;
    r    = 8'h01;
    base = b;
    e    = 8'd254;
    for (int i = 0; i < 8; i++) begin
      if (e[i]) r = gmul(r, base);
      base = gmul(base, base);
    end
    return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^
           {r[3:0], r[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [127:0] sub_bytes(input logic [127:0] s);
    logic [127:0] r;
    r = '0;
    for (int k = 0; k < 16; k++) r[8*(15-k) +: 8] = sbox(s[8*(15-k) +: 8]);
    return r;
  endfunction

  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] r;
    r = '0;
    for (int row = 0; row < 4; row++) begin
      for (int col = 0; col < 4; col++) begin
        r[8*(15-(row+4*col)) +: 8] = s[8*(15-(row+4*((col+row)%4))) +: 8];
      end
    end
    return r;
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    logic [127:0] r;
    logic [7:0]   a0, a1, a2, a3;
    r = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[8*(15-4*c) +: 8];
      a1 = s[8*(14-4*c) +: 8];
      a2 = s[8*(13-4*c) +: 8];
      a3 = s[8*(12-4*c) +: 8];
      r[8*(15-4*c) +: 8] = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
      r[8*(14-4*c) +: 8] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
      r[8*(13-4*c) +: 8] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
      r[8*(12-4*c) +: 8] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
    end
    return r;
  endfunction

  function automatic logic [127:0] next_key(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] w0, w1, w2, w3, t;
    w0 = k[127:96];
    w1 = k[95:64];
    w2 = k[63:32];
    w3 = k[31:0];
    t  = {sbox(w3[23:16]), sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])};
    t  = t ^ {rc, 24'h000000};
    w0 = w0 ^ t;
    w1 = w1 ^ w0;
    w2 = w2 ^ w1;
    w3 = w3 ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  function automatic logic [127:0] aes128(input logic [127:0] k, input logic [127:0] pt);
    logic [127:0] s;
    logic [127:0] rk;
    logic [7:0]   rc;
    rk = k;
    rc = 8'h01;
    s  = pt ^ rk;
    for (int rnd = 1; rnd <= 10; rnd++) begin
      rk = next_key(rk, rc);
      rc = gmul(rc, 8'h02);
      s  = shift_rows(sub_bytes(s));
      if (rnd != 10) s = mix_columns(s);
      s  = s ^ rk;
    end
    return s;
  endfunction

  // Chained plaintext encrypted under the supplied key.
  always_comb begin
    out = aes128(key, in ^ iv);
  end

endmodule

// File: rtl/aes_cbc_chain_ctrl.sv
// Sequential CBC-mode front end for a combinational AES encrypt core.
// Optional build macro: AES_CBC_BLKCNT_EN adds a saturating blk_cnt output
// counting ciphertext handshakes since the last accepted start.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high; valid, once raised, holds its data stable until that edge, and
// ready never depends combinationally on valid.
module aes_cbc_chain_ctrl
  import aes_cbc_pkg::*;
#(
  parameter int ENC_LAT = 1,
  parameter int CNT_W   = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [AES_BLK_W-1:0] key,
  input  logic [AES_BLK_W-1:0] iv_in,
  input  logic                 pt_valid,
  input  logic [AES_BLK_W-1:0] pt_data,
  input  logic                 pt_last,
  output logic                 pt_ready,
  output logic                 ct_valid,
  output logic [AES_BLK_W-1:0] ct_data,
  output logic                 ct_last,
  input  logic                 ct_ready,
  output logic [AES_BLK_W-1:0] enc_in,
  output logic [AES_BLK_W-1:0] enc_iv,
  output logic [AES_BLK_W-1:0] enc_key,
  input  logic [AES_BLK_W-1:0] enc_out,
  output logic                 busy,
  output state_t               dbg_state
`ifdef AES_CBC_BLKCNT_EN
  ,
  output logic [CNT_W-1:0]     blk_cnt
`endif
);

  if (ENC_LAT < 1) begin : g_bad_enc_lat
    $error("aes_cbc_chain_ctrl: ENC_LAT must be at least 1");
  end
  if (CNT_W < 1) begin : g_bad_cnt_w
    $error("aes_cbc_chain_ctrl: CNT_W must be at least 1");
  end

  state_t state, state_nx;

  logic [AES_BLK_W-1:0] iv_reg;
  logic [AES_BLK_W-1:0] key_reg;
  logic [AES_BLK_W-1:0] pt_reg;
  logic                 last_reg;
  logic                 lat_done;
  logic                 start_acc;
  logic                 pt_hs;
  logic                 ct_hs;

  // Handshake qualifiers are taken from the state register so that
  // ready/busy stay free of input-to-output paths.
  assign start_acc = (state == ST_IDLE) && start;
  assign pt_hs     = (state == ST_ACCEPT) && pt_valid;
  assign ct_hs     = (state == ST_OUT) && ct_ready;

  assign pt_ready  = (state == ST_ACCEPT);
  assign busy      = (state != ST_IDLE);
  assign dbg_state = state;

  assign enc_in  = pt_reg;
  assign enc_iv  = iv_reg;
  assign enc_key = key_reg;

  aes_cbc_lat_cnt #(
    .ENC_LAT (ENC_LAT)
  ) u_lat_cnt (
    .clk  (clk),
    .rst  (rst),
    .clr  (pt_hs),
    .en   (state == ST_WAIT),
    .done (lat_done)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state decode: one block in flight at a time, no overlap.
  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:   if (start)    state_nx = ST_ACCEPT;
      ST_ACCEPT: if (pt_valid) state_nx = ST_WAIT;
      ST_WAIT:   if (lat_done) state_nx = ST_OUT;
      ST_OUT:    if (ct_ready) state_nx = ct_last ? ST_IDLE : ST_ACCEPT;
      default:                 state_nx = ST_IDLE;
    endcase
  end

  // Key/IV latch, plaintext capture, ciphertext capture and IV chaining.
  always_ff @(posedge clk) begin
    if (rst) begin
      iv_reg   <= '0;
      key_reg  <= '0;
      pt_reg   <= '0;
      last_reg <= 1'b0;
      ct_data  <= '0;
      ct_last  <= 1'b0;
      ct_valid <= 1'b0;
    end else begin
      if (start_acc) begin
        iv_reg  <= iv_in;
        key_reg <= key;
      end
      if (pt_hs) begin
        pt_reg   <= pt_data;
        last_reg <= pt_last;
      end
      if ((state == ST_WAIT) && lat_done) begin
        ct_data  <= enc_out;
        ct_last  <= last_reg;
        ct_valid <= 1'b1;
      end
      if (ct_hs) begin
        iv_reg   <= ct_data;
        ct_valid <= 1'b0;
      end
    end
  end

`ifdef AES_CBC_BLKCNT_EN
  // Ciphertext handshake counter, cleared per message, saturating at all-ones.
  always_ff @(posedge clk) begin
    if (rst || start_acc) begin
      blk_cnt <= '0;
    end else if (ct_hs && (blk_cnt != {CNT_W{1'b1}})) begin
      blk_cnt <= blk_cnt + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_aes_cbc_chain_ctrl.sv
// Directed bench for aes_cbc_chain_ctrl driving the aes_enc_top core with
// SP800-38A F.2.1 CBC-AES128 vectors. Build with AES_CBC_BLKCNT_EN to also
// exercise the block counter.
module tb_aes_cbc_chain_ctrl;
  import aes_cbc_pkg::*;

  localparam int ENC_LAT = 3;
  localparam int CNT_W   = 2;

  localparam logic [127:0] K   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] IV  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PT1 = 128'h6bc1bee22e409f96e93d7e117393172a;
  localparam logic [127:0] PT2 = 128'hae2d8a571e03ac9c9eb76fac45af8e51;
  localparam logic [127:0] PT3 = 128'h30c81c46a35ce411e5fbc1191a0a52ef;
  localparam logic [127:0] PT4 = 128'hf69f2445df4f9b17ad2b417be66c3710;
  localparam logic [127:0] CT1 = 128'h7649abac8119b246cee98e9b12e9197d;
  localparam logic [127:0] CT2 = 128'h5086cb9b507219ee95db113a917678b2;
  localparam logic [127:0] CT3 = 128'h73bed6b8e3c1743b7116e69e22229516;
  localparam logic [127:0] CT4 = 128'h3ff1caa1681fac09120eca307586e1a7;

  logic         clk;
  logic         rst;
  logic         start;
  logic [127:0] key;
  logic [127:0] iv_in;
  logic         pt_valid;
  logic [127:0] pt_data;
  logic         pt_last;
  logic         pt_ready;
  logic         ct_valid;
  logic [127:0] ct_data;
  logic         ct_last;
  logic         ct_ready;
  logic [127:0] enc_in;
  logic [127:0] enc_iv;
  logic [127:0] enc_key;
  logic [127:0] enc_out;
  logic         busy;
  state_t       dbg_state;
`ifdef AES_CBC_BLKCNT_EN
  logic [CNT_W-1:0] blk_cnt;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int edges;
  bit seen;

  // Scoreboard: {ct_last, ct_data} expected in order.
  logic [128:0] exp_q[$];

  aes_cbc_chain_ctrl #(
    .ENC_LAT (ENC_LAT),
    .CNT_W   (CNT_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .key       (key),
    .iv_in     (iv_in),
    .pt_valid  (pt_valid),
    .pt_data   (pt_data),
    .pt_last   (pt_last),
    .pt_ready  (pt_ready),
    .ct_valid  (ct_valid),
    .ct_data   (ct_data),
    .ct_last   (ct_last),
    .ct_ready  (ct_ready),
    .enc_in    (enc_in),
    .enc_iv    (enc_iv),
    .enc_key   (enc_key),
    .enc_out   (enc_out),
    .busy      (busy),
    .dbg_state (dbg_state)
`ifdef AES_CBC_BLKCNT_EN
    ,
    .blk_cnt   (blk_cnt)
`endif
  );

  aes_enc_top u_core (
    .in  (enc_in),
    .iv  (enc_iv),
    .key (enc_key),
    .out (enc_out)
  );

  // Clock and watchdog.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic do_start(input logic [127:0] k, input logic [127:0] v);
    start = 1'b1;
    key   = k;
    iv_in = v;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Offers one plaintext block; returns 1 time unit after the handshake edge.
  task automatic put_pt(input logic [127:0] d, input logic l);
    bit ok;
    ok       = 1'b0;
    pt_valid = 1'b1;
    pt_data  = d;
    pt_last  = l;
    for (int n = 0; n < 20 && !ok; n++) begin
      @(negedge clk);
      if (pt_ready) ok = 1'b1;
      @(posedge clk);
      #1;
    end
    pt_valid = 1'b0;
    check("pt_accept", 128'(ok), 128'(1));
  endtask

  // Counts edges from the plaintext handshake until ct_valid is seen.
  task automatic wait_ct(output int n_edges);
    n_edges = 0;
    for (int n = 1; n <= 20 && n_edges == 0; n++) begin
      @(posedge clk);
      #1;
      if (ct_valid) n_edges = n;
    end
    check("ct_valid_seen", 128'(ct_valid), 128'(1));
  endtask

  task automatic check_ct(input string tag);
    logic [128:0] e;
    check({tag, "_q_nonempty"}, 128'(exp_q.size() != 0), 128'(1));
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check({tag, "_data"}, ct_data, e[127:0]);
      check({tag, "_last"}, 128'(ct_last), 128'(e[128]));
    end
  endtask

  initial begin
    rst      = 1'b1;
    start    = 1'b0;
    key      = '0;
    iv_in    = '0;
    pt_valid = 1'b0;
    pt_data  = '0;
    pt_last  = 1'b0;
    ct_ready = 1'b0;

    // Reset values.
    do_reset();
    check("rst_pt_ready", 128'(pt_ready), 128'(0));
    check("rst_ct_valid", 128'(ct_valid), 128'(0));
    check("rst_ct_last", 128'(ct_last), 128'(0));
    check("rst_ct_data", ct_data, 128'(0));
    check("rst_busy", 128'(busy), 128'(0));
    check("rst_enc_iv", enc_iv, 128'(0));
    check("rst_enc_key", enc_key, 128'(0));
    check("rst_enc_in", enc_in, 128'(0));
    check("rst_state", 128'(dbg_state), 128'(ST_IDLE));

    // pt_valid without start is ignored in IDLE.
    pt_valid = 1'b1;
    pt_data  = PT1;
    repeat (3) @(posedge clk);
    #1;
    check("idle_pt_ready", 128'(pt_ready), 128'(0));
    check("idle_busy", 128'(busy), 128'(0));
    check("idle_ct_valid", 128'(ct_valid), 128'(0));
    check("idle_enc_in", enc_in, 128'(0));
    pt_valid = 1'b0;

    // start together with rst: reset wins.
    start = 1'b1;
    key   = K;
    iv_in = IV;
    rst   = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    start = 1'b0;
    check("rst_start_busy", 128'(busy), 128'(0));
    check("rst_start_key", enc_key, 128'(0));
    check("rst_start_iv", enc_iv, 128'(0));

    // Start message; later key/iv_in changes have no effect.
    do_start(K, IV);
    check("start_busy", 128'(busy), 128'(1));
    check("start_pt_ready", 128'(pt_ready), 128'(1));
    check("start_state", 128'(dbg_state), 128'(ST_ACCEPT));
    key   = ~K;
    iv_in = ~IV;
    @(posedge clk);
    #1;
    check("latched_key", enc_key, K);
    check("latched_iv", enc_iv, IV);

    // Two-block F.2.1 message, sink always ready.
    ct_ready = 1'b1;
    exp_q.push_back({1'b0, CT1});
    put_pt(PT1, 1'b0);
    check("blk1_enc_in", enc_in, PT1);
    check("blk1_state_wait", 128'(dbg_state), 128'(ST_WAIT));
    wait_ct(edges);
    check("latency", 128'(edges), 128'(ENC_LAT));
    check_ct("blk1");
    @(posedge clk);
    #1;
    check("chain_iv1", enc_iv, CT1);
    check("after_blk1_state", 128'(dbg_state), 128'(ST_ACCEPT));
    check("after_blk1_ct_valid", 128'(ct_valid), 128'(0));
    exp_q.push_back({1'b1, CT2});
    put_pt(PT2, 1'b1);
    wait_ct(edges);
    check("latency2", 128'(edges), 128'(ENC_LAT));
    check_ct("blk2");
    @(posedge clk);
    #1;
    check("msg1_end_busy", 128'(busy), 128'(0));
    check("msg1_end_state", 128'(dbg_state), 128'(ST_IDLE));

    // Backpressure: ct_ready low for 5 cycles while a new block is offered.
    ct_ready = 1'b0;
    do_start(K, IV);
    exp_q.push_back({1'b0, CT1});
    put_pt(PT1, 1'b0);
    wait_ct(edges);
    check_ct("bp_blk1");
    pt_valid = 1'b1;
    pt_data  = PT3;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check("bp_ct_valid", 128'(ct_valid), 128'(1));
      check("bp_ct_data", ct_data, CT1);
      check("bp_pt_ready", 128'(pt_ready), 128'(0));
      check("bp_enc_iv", enc_iv, IV);
    end
    pt_valid = 1'b0;
    ct_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp_chain_iv", enc_iv, CT1);
    check("bp_state", 128'(dbg_state), 128'(ST_ACCEPT));
    exp_q.push_back({1'b1, CT2});
    put_pt(PT2, 1'b1);
    wait_ct(edges);
    check_ct("bp_blk2");
    @(posedge clk);
    #1;
    check("bp_end_busy", 128'(busy), 128'(0));

    // Reset pulsed while the block is in WAIT.
    do_start(K, IV);
    put_pt(PT1, 1'b0);
    check("mid_state_wait", 128'(dbg_state), 128'(ST_WAIT));
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    check("mid_rst_ct_valid", 128'(ct_valid), 128'(0));
    check("mid_rst_iv", enc_iv, 128'(0));
    check("mid_rst_key", enc_key, 128'(0));
    check("mid_rst_enc_in", enc_in, 128'(0));
    check("mid_rst_state", 128'(dbg_state), 128'(ST_IDLE));
    seen = 1'b0;
    repeat (6) begin
      @(posedge clk);
      #1;
      if (ct_valid) seen = 1'b1;
    end
    check("mid_rst_no_ct", 128'(seen), 128'(0));

    // start asserted in OUT is ignored; chaining uses the ciphertext.
    ct_ready = 1'b0;
    do_start(K, IV);
    exp_q.push_back({1'b0, CT1});
    put_pt(PT1, 1'b0);
    wait_ct(edges);
    check_ct("out_start_blk1");
    start = 1'b1;
    key   = ~K;
    iv_in = ~IV;
    repeat (2) @(posedge clk);
    #1;
    check("out_start_state", 128'(dbg_state), 128'(ST_OUT));
    check("out_start_key", enc_key, K);
    ct_ready = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    check("out_start_iv", enc_iv, CT1);
    check("out_start_key2", enc_key, K);
    check("out_start_accept", 128'(dbg_state), 128'(ST_ACCEPT));
    exp_q.push_back({1'b1, CT2});
    put_pt(PT2, 1'b1);
    wait_ct(edges);
    check_ct("out_start_blk2");
    @(posedge clk);
    #1;
    check("out_start_end_busy", 128'(busy), 128'(0));

`ifdef AES_CBC_BLKCNT_EN
    // Block counter: two handshakes since the last start, then saturation.
    check("blkcnt_prev", 128'(blk_cnt), 128'(2));
    do_start(K, IV);
    check("blkcnt_clear", 128'(blk_cnt), 128'(0));
    exp_q.push_back({1'b0, CT1});
    exp_q.push_back({1'b0, CT2});
    exp_q.push_back({1'b0, CT3});
    exp_q.push_back({1'b0, CT4});
    put_pt(PT1, 1'b0); wait_ct(edges); check_ct("cnt_blk1"); @(posedge clk); #1;
    put_pt(PT2, 1'b0); wait_ct(edges); check_ct("cnt_blk2"); @(posedge clk); #1;
    check("blkcnt_two", 128'(blk_cnt), 128'(2));
    put_pt(PT3, 1'b0); wait_ct(edges); check_ct("cnt_blk3"); @(posedge clk); #1;
    put_pt(PT4, 1'b0); wait_ct(edges); check_ct("cnt_blk4"); @(posedge clk); #1;
    put_pt(PT1, 1'b1); wait_ct(edges);
    check("cnt_blk5_last", 128'(ct_last), 128'(1));
    @(posedge clk);
    #1;
    check("blkcnt_sat", 128'(blk_cnt), 128'(3));
    check("blkcnt_end_busy", 128'(busy), 128'(0));
    do_start(K, IV);
    check("blkcnt_restart", 128'(blk_cnt), 128'(0));
`endif

    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
